alu_arbiter: RTL

- Shares one 32-bit ALU datapath (ADD/AND/OR/MUL/SUB/SLT) between two requesters.
- Round-robin arbitration, valid/ready handshakes on both sides, a multi-cycle multiply, and a registered result with zero flag.
- Sits between two issuing units and the ALU. One operation is in flight at a time; a response is held until it is consumed.

---
 rtl/alu_arbiter_if.sv | 33 +++
 rtl/alu_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between two issuers, the shared ALU and its consumer
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_r;
  logic        rsp_z;
  logic        busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_r, rsp_z, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_r, rsp_z, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one 32-bit ALU (multi-cycle MUL) between two requesters
module alu_arbiter #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] OP_MUL = 3'b100;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        id_q, id_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        prio_q, prio_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_r_q, rsp_r_d;
  logic        rsp_z_q, rsp_z_d;

  logic [31:0] alu_r;
  logic        any_valid;
  logic        winner;
  logic        req0_ready_c, req1_ready_c;

  always_comb begin
    alu_r = '0;
    case (op_q)
      3'b001:  alu_r = a_q + b_q;
      3'b010:  alu_r = a_q & b_q;
      3'b011:  alu_r = a_q | b_q;
      3'b100:  alu_r = a_q * b_q;
      3'b101:  alu_r = a_q - b_q;
      3'b110:  alu_r = {31'b0, (a_q < b_q)};
      default: alu_r = '0;
    endcase
  end

  // prio_q names the requester that wins a tie; it flips away from each winner
  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign winner    = (bus.req0_valid & bus.req1_valid) ? prio_q : bus.req1_valid;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    prio_d       = prio_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_r_d      = rsp_r_q;
    rsp_z_d      = rsp_z_q;
    req0_ready_c = 1'b0;
    req1_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          req0_ready_c = ~winner;
          req1_ready_c = winner;
          op_d    = winner ? bus.req1_op : bus.req0_op;
          a_d     = winner ? bus.req1_a  : bus.req0_a;
          b_d     = winner ? bus.req1_b  : bus.req0_b;
          id_d    = winner;
          prio_d  = ~winner;
          cnt_d   = (op_d == OP_MUL) ? 4'(MUL_LAT - 1) : 4'd0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_r_d     = alu_r;
          rsp_z_d     = (alu_r == 32'd0);
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      prio_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_r_q     <= '0;
      rsp_z_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_r_q     <= rsp_r_d;
      rsp_z_q     <= rsp_z_d;
    end
  end

  assign bus.req0_ready = req0_ready_c;
  assign bus.req1_ready = req1_ready_c;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_r      = rsp_r_q;
  assign bus.rsp_z      = rsp_z_q;
  assign bus.busy       = (state_q != IDLE);
endmodule
